// File: rtl/tw_gen_mc_if.sv
// Twiddle generator bus: frame control, table write port and twiddle output.
// The master drives frames and table writes; the slave returns NCH twiddles per beat.
interface tw_gen_mc_if #(
  parameter int LOGQ = 16,
  parameter int NCH  = 2,
  parameter int AW   = 3
);
  logic                  start;
  logic                  intt;
  logic [LOGQ-1:0]       q;
  logic                  in_valid;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [LOGQ-1:0]       wr_data;
  logic [NCH*LOGQ-1:0]   dout;
  logic                  out_valid;
  logic                  out_last;
  logic                  busy;
  logic                  wr_err;

  modport master (
    output start, intt, q, in_valid, wr_en, wr_addr, wr_data,
    input  dout, out_valid, out_last, busy, wr_err
  );

  modport slave (
    input  start, intt, q, in_valid, wr_en, wr_addr, wr_data,
    output dout, out_valid, out_last, busy, wr_err
  );
endinterface

// File: rtl/tw_gen_mc.sv
// Multi-lane NTT/INTT twiddle generator: per-lane replicated twiddle tables read
// in lock-step with butterfly groups, with the INTT negation (q - t) applied at the output.
module tw_gen_mc #(
  parameter int LOGQ       = 16,
  parameter int LOGN       = 10,
  parameter int STAGE      = 3,
  parameter int NCH        = 2,
  parameter int DELAY_BROM = 2,
  parameter int TYPE_RED   = 0,
  parameter int R_w        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tw_gen_mc_if.slave  bus
);

  localparam int TD    = 1 << STAGE;
  localparam int AW    = (STAGE > 0) ? STAGE : 1;
  localparam int FRAME = (1 << LOGN) / (2 * NCH);
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DB    = DELAY_BROM;

  localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME - 1);
  localparam logic [LOGQ-1:0] U        = (TYPE_RED != 0) ? LOGQ'(R_w) : LOGQ'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_intt;
  logic [LOGQ-1:0] r_q;

  logic            w_run;
  logic            w_last_old;
  logic            w_new;
  logic            w_beat;
  logic [CW-1:0]   w_cnt;
  logic            w_intt;
  logic [LOGQ-1:0] w_q;
  logic            w_last;
  logic            w_wr_ok;

  assign w_run   = (r_state == RUN);
  // A start arriving together with the final beat of a running frame lets that beat
  // finish the old frame; the new frame then begins at the next beat with cnt = 0.
  assign w_last_old = w_run && bus.in_valid && bus.start && (r_cnt == LAST_CNT);
  assign w_new   = bus.start && !w_last_old;
  assign w_beat  = bus.in_valid && (w_run || bus.start);
  assign w_cnt   = w_new ? '0 : r_cnt;
  assign w_intt  = w_new ? bus.intt : r_intt;
  assign w_q     = w_new ? bus.q : r_q;
  assign w_last  = (w_cnt == LAST_CNT);
  assign w_wr_ok = bus.wr_en && !w_run && !bus.start;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_intt  <= 1'b0;
      r_q     <= '0;
    end else begin
      if (bus.start) begin
        r_intt <= bus.intt;
        r_q    <= bus.q;
      end
      if (w_last_old) begin
        r_state <= RUN;
        r_cnt   <= '0;
      end else if (w_beat) begin
        r_cnt   <= w_last ? '0 : w_cnt + 1'b1;
        r_state <= w_last ? IDLE : RUN;
      end else if (bus.start) begin
        r_state <= RUN;
        r_cnt   <= '0;
      end
    end
  end

  logic [LOGQ-1:0] w_raw [NCH];

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      if (STAGE > 0) begin : g_tab
        logic [LOGQ-1:0] r_mem [TD];
        logic [AW-1:0]   w_idx;

        // NOTE: table storage has no reset; its contents survive rst_n and are only
        // changed through the write port, which keeps it mappable onto block RAM.
        always_ff @(posedge clk) begin
          if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
        end

        assign w_idx    = AW'(32'(w_cnt) * NCH + k);
        assign w_raw[k] = r_mem[w_idx];
      end else begin : g_unity
        assign w_raw[k] = U;
      end
    end
  endgenerate

  // Read pipeline: DB stages from the issuing edge to the output register.
  logic            r_vld   [DB];
  logic            r_plast [DB];
  logic            r_pintt [DB];
  logic [LOGQ-1:0] r_pq    [DB];
  logic [LOGQ-1:0] r_rd    [DB][NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DB; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= w_beat;
      for (int i = 1; i < DB; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_plast[0] <= w_last;
    r_pintt[0] <= w_intt;
    r_pq[0]    <= w_q;
    for (int l = 0; l < NCH; l++) r_rd[0][l] <= w_raw[l];
    for (int i = 1; i < DB; i++) begin
      r_plast[i] <= r_plast[i-1];
      r_pintt[i] <= r_pintt[i-1];
      r_pq[i]    <= r_pq[i-1];
      for (int l = 0; l < NCH; l++) r_rd[i][l] <= r_rd[i-1][l];
    end
  end

  logic [NCH*LOGQ-1:0] w_dout;

  generate
    for (k = 0; k < NCH; k++) begin : g_out
      logic [LOGQ-1:0] w_t;
      assign w_t = r_rd[DB-1][k];
      assign w_dout[k*LOGQ +: LOGQ] = (r_pintt[DB-1] && (w_t != U)) ? (r_pq[DB-1] - w_t) : w_t;
    end
  endgenerate

  logic [NCH*LOGQ-1:0] r_dout;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_out_valid <= r_vld[DB-1];
      r_out_last  <= r_vld[DB-1] && r_plast[DB-1];
      r_wr_err    <= bus.wr_en && !w_wr_ok;
      if (r_vld[DB-1]) r_dout <= w_dout;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.wr_err    = r_wr_err;
  assign bus.busy      = w_run;

endmodule

// File: tb/tb_tw_gen_mc.sv
// Bench for tw_gen_mc: three instances (plain table, Montgomery unity 7, no table)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_tw_gen_mc;

  localparam int LOGQ  = 16;
  localparam int LOGN  = 4;
  localparam int NCH   = 2;
  localparam int STAGE = 2;
  localparam int DB    = 2;
  localparam int TD    = 4;
  localparam int FRAME = 4;
  localparam int NDUT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_start, s_intt, s_in_valid, s_wr_en;
  logic [15:0] s_q, s_wr_data;
  logic [1:0]  s_wr_addr;

  tw_gen_mc_if #(.LOGQ(LOGQ), .NCH(NCH), .AW(2)) if_a ();
  tw_gen_mc_if #(.LOGQ(LOGQ), .NCH(NCH), .AW(2)) if_b ();
  tw_gen_mc_if #(.LOGQ(LOGQ), .NCH(NCH), .AW(1)) if_c ();

  assign if_a.start = s_start;  assign if_b.start = s_start;  assign if_c.start = s_start;
  assign if_a.intt  = s_intt;   assign if_b.intt  = s_intt;   assign if_c.intt  = s_intt;
  assign if_a.q     = s_q;      assign if_b.q     = s_q;      assign if_c.q     = s_q;
  assign if_a.in_valid = s_in_valid; assign if_b.in_valid = s_in_valid; assign if_c.in_valid = s_in_valid;
  assign if_a.wr_en = s_wr_en;  assign if_b.wr_en = s_wr_en;  assign if_c.wr_en = s_wr_en;
  assign if_a.wr_addr = s_wr_addr; assign if_b.wr_addr = s_wr_addr; assign if_c.wr_addr = s_wr_addr[0];
  assign if_a.wr_data = s_wr_data; assign if_b.wr_data = s_wr_data; assign if_c.wr_data = s_wr_data;

  tw_gen_mc #(.LOGQ(LOGQ), .LOGN(LOGN), .STAGE(STAGE), .NCH(NCH), .DELAY_BROM(DB),
              .TYPE_RED(0), .R_w(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  tw_gen_mc #(.LOGQ(LOGQ), .LOGN(LOGN), .STAGE(STAGE), .NCH(NCH), .DELAY_BROM(DB),
              .TYPE_RED(1), .R_w(7)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  tw_gen_mc #(.LOGQ(LOGQ), .LOGN(LOGN), .STAGE(0), .NCH(NCH), .DELAY_BROM(DB),
              .TYPE_RED(0), .R_w(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one expected-output queue per instance, due at an absolute edge.
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        last;
  } exp_t;

  exp_t        q_exp [NDUT][$];
  logic [31:0] log_d [NDUT][$];
  logic [31:0] hold  [NDUT];
  int unsigned tab   [TD];
  bit          m_run, m_intt, exp_wr_err;
  int          m_cnt;
  int unsigned m_q;
  int          edge_n;

  function automatic int unsigned unity(input int d);
    return (d == 1) ? 7 : 1;
  endfunction

  function automatic logic [31:0] lanes(input int d, input int cnt, input bit intt,
                                        input int unsigned q);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      int unsigned t, v;
      t = (d == 2) ? unity(d) : tab[(cnt * NCH + k) % TD];
      v = (intt && t != unity(d)) ? ((q - t) & 32'hFFFF) : t;
      r[k*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_intt = 0; m_q = 0; exp_wr_err = 0;
    for (int d = 0; d < NDUT; d++) begin
      q_exp[d].delete();
      hold[d] = '0;
    end
  endtask

  task automatic model_edge();
    bit last_old, new_fr, beat, bi;
    int bcnt;
    int unsigned bq;
    exp_t e;
    edge_n++;
    if (!rst_n) return;
    last_old = m_run && s_in_valid && s_start && (m_cnt == FRAME - 1);
    new_fr   = s_start && !last_old;
    beat     = s_in_valid && (m_run || s_start);
    bcnt     = new_fr ? 0 : m_cnt;
    bi       = new_fr ? s_intt : m_intt;
    bq       = new_fr ? 32'(s_q) : m_q;
    if (beat) begin
      for (int d = 0; d < NDUT; d++) begin
        e.due  = edge_n + DB;
        e.d    = lanes(d, bcnt, bi, bq);
        e.last = (bcnt == FRAME - 1);
        q_exp[d].push_back(e);
      end
    end
    exp_wr_err = s_wr_en && (m_run || s_start);
    if (s_wr_en && !exp_wr_err) tab[s_wr_addr] = 32'(s_wr_data);
    if (s_start) begin
      m_intt = s_intt;
      m_q    = 32'(s_q);
    end
    if (last_old) begin
      m_run = 1; m_cnt = 0;
    end else if (beat) begin
      m_run = (bcnt != FRAME - 1);
      m_cnt = (bcnt + 1) % FRAME;
    end else if (s_start) begin
      m_run = 1; m_cnt = 0;
    end
  endtask

  task automatic cmp_dut(input int d, input string nm, input logic [31:0] dv, input logic ov,
                         input logic ol, input logic bz, input logic we);
    exp_t e;
    if (q_exp[d].size() > 0 && q_exp[d][0].due == edge_n) begin
      e = q_exp[d].pop_front();
      check($sformatf("%s out_valid @%0d", nm, edge_n), ov, 1'b1);
      check($sformatf("%s dout @%0d", nm, edge_n), dv, e.d);
      check($sformatf("%s out_last @%0d", nm, edge_n), ol, e.last);
      hold[d] = e.d;
    end else begin
      check($sformatf("%s idle out_valid @%0d", nm, edge_n), ov, 1'b0);
      check($sformatf("%s held dout @%0d", nm, edge_n), dv, hold[d]);
      check($sformatf("%s idle out_last @%0d", nm, edge_n), ol, 1'b0);
    end
    if (ov === 1'b1) log_d[d].push_back(dv);
    check($sformatf("%s busy @%0d", nm, edge_n), bz, m_run);
    check($sformatf("%s wr_err @%0d", nm, edge_n), we, exp_wr_err);
  endtask

  task automatic compare();
    cmp_dut(0, "a", if_a.dout, if_a.out_valid, if_a.out_last, if_a.busy, if_a.wr_err);
    cmp_dut(1, "b", if_b.dout, if_b.out_valid, if_b.out_last, if_b.busy, if_b.wr_err);
    cmp_dut(2, "c", if_c.dout, if_c.out_valid, if_c.out_last, if_c.busy, if_c.wr_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input bit st, input bit it, input int unsigned qq, input bit iv,
                       input bit we, input int unsigned wa, input int unsigned wd);
    s_start = st; s_intt = it; s_q = qq[15:0]; s_in_valid = iv;
    s_wr_en = we; s_wr_addr = wa[1:0]; s_wr_data = wd[15:0];
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    s_start = 0; s_in_valid = 0; s_wr_en = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < NDUT; d++) log_d[d].delete();
  endtask

  task automatic check_log(input int d, input string nm, input logic [31:0] ev [4]);
    check($sformatf("%s beat count", nm), log_d[d].size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s beat %0d lanes", nm, i), log_d[d][i], ev[i]);
  endtask

  initial begin
    int unsigned init_tab [4];
    logic [31:0] ev [4];
    init_tab = '{1, 5, 7, 9};
    edge_n = 0;
    for (int i = 0; i < TD; i++) tab[i] = 0;
    s_start = 0; s_intt = 0; s_q = '0; s_in_valid = 0;
    s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 compare();
    cycle();
    cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, i, init_tab[i]);
    drive(0, 0, 0, 1, 0, 0, 0);

    // Forward frame: (1,5),(7,9),(1,5),(7,9)
    clear_logs();
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);
    idle(5);
    ev = '{32'h0005_0001, 32'h0009_0007, 32'h0005_0001, 32'h0009_0007};
    check_log(0, "fwd a", ev);

    // Inverse frame, q = 17
    clear_logs();
    drive(1, 1, 17, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);
    idle(5);
    ev = '{32'h000C_0001, 32'h0008_000A, 32'h000C_0001, 32'h0008_000A};
    check_log(0, "inv a", ev);
    ev = '{32'h000C_0010, 32'h0008_0007, 32'h000C_0010, 32'h0008_0007};
    check_log(1, "inv b", ev);
    ev = '{32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001};
    check_log(2, "inv c", ev);

    // Dropped writes, then a restart on the last beat
    clear_logs();
    drive(1, 0, 0, 1, 1, 0, 100);
    drive(0, 0, 0, 1, 1, 1, 200);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 17, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0);
    idle(5);
    check("chain beat count", log_d[0].size(), 8);
    check("chain old table", log_d[0][1], 32'h0009_0007);
    check("chain seamless", log_d[0][4], 32'h000C_0001);

    // Mid-frame abort
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 17, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0);
    idle(4);

    // Reset with two beats in flight
    drive(1, 1, 23, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    do_reset();
    idle(4);
    drive(1, 1, 23, 1, 0, 0, 0);
    idle(5);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned wd;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0:       wd = 1;
          1:       wd = 7;
          default: wd = $urandom_range(0, 65535);
        endcase
        drive($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 65535),
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3), wd);
      end
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
